// File: rtl/nibble_scan_ctrl_pkg.sv
// Shared state encoding and constants for the nibble scan controller.
package nibble_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] LAST_CODE = 4'd15;

endpackage

// File: rtl/nibble_scan_ctrl_timer.sv
// Hold-cycle counter: flags the settle-sample cycle and the last hold cycle
// of each code driven by the scan controller.
module scan_hold_timer #(
  parameter int TICK_DIV = 4,
  parameter int SETTLE   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic sample_pulse_o,
  output logic step_pulse_o
);

  if (TICK_DIV < 2 || SETTLE < 0 || SETTLE >= TICK_DIV) begin : g_bad_param
    $error("scan_hold_timer: need TICK_DIV>=2 and 0<=SETTLE<TICK_DIV");
  end

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  localparam logic [W-1:0] SAMP = W'(SETTLE);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign sample_pulse_o = en_i && !clr_i && (cnt_q == SAMP);
  assign step_pulse_o   = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/nibble_scan_ctrl.sv
// Drives codes 0..15 into a 4-bit combinational block, samples its F output
// and builds a truth vector plus a count of ones.
module nibble_scan_ctrl
  import nibble_scan_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int SETTLE   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  output logic [3:0]  n_out,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [15:0] truth,
  output logic [4:0]  minterm_cnt
);

  state_e      st_q, st_d;
  logic [3:0]  n_q, n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;
  logic [15:0] truth_q, truth_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sample_p, step_p;
  logic        t_clr, t_en;

  // Timer only runs in DRIVE; any abort leaves it cleared for the next scan.
  assign t_en  = (st_q == ST_DRIVE);
  assign t_clr = (st_q != ST_DRIVE) || abort;

  scan_hold_timer #(
    .TICK_DIV (TICK_DIV),
    .SETTLE   (SETTLE)
  ) u_timer (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr_i          (t_clr),
    .en_i           (t_en),
    .sample_pulse_o (sample_p),
    .step_pulse_o   (step_p)
  );

  always_comb begin
    st_d    = st_q;
    n_d     = n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    truth_d = truth_q;
    cnt_d   = cnt_q;
    unique case (st_q)
      ST_IDLE: begin
        if (start && !abort) begin
          st_d    = ST_DRIVE;
          n_d     = 4'd0;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          truth_d = '0;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (abort) begin
          st_d    = ST_IDLE;
          n_d     = 4'd0;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          truth_d = '0;
          cnt_d   = '0;
        end else begin
          if (sample_p) begin
            truth_d[n_q] = f_in;
            cnt_d        = cnt_q + {4'd0, f_in};
          end
          if (step_p) begin
            if (n_q == LAST_CODE) begin
              st_d    = ST_DONE;
              n_d     = 4'd0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              valid_d = 1'b1;
            end else begin
              n_d = n_q + 4'd1;
            end
          end
        end
      end
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      n_q     <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      truth_q <= '0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      truth_q <= truth_d;
      cnt_q   <= cnt_d;
    end
  end

  assign n_out       = n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign valid       = valid_q;
  assign truth       = truth_q;
  assign minterm_cnt = cnt_q;

endmodule

// File: tb/tb_nibble_scan_ctrl.sv
// Self-checking bench for nibble_scan_ctrl (TICK_DIV=4, SETTLE=2).
module tb_nibble_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, f_in;
  logic [3:0]  n_out;
  logic        busy, done, valid;
  logic [15:0] truth;
  logic [4:0]  minterm_cnt;

  int          mode;
  logic [15:0] lut;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  nibble_scan_ctrl #(.TICK_DIV(4), .SETTLE(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .f_in        (f_in),
    .n_out       (n_out),
    .busy        (busy),
    .done        (done),
    .valid       (valid),
    .truth       (truth),
    .minterm_cnt (minterm_cnt)
  );

  function automatic logic fmodel(int m, logic [15:0] l, int i);
    logic [3:0] n;
    n = 4'(i);
    case (m)
      0:       return (n == 4'd5) || (n == 4'd10);
      1:       return ^n;
      2:       return 1'b1;
      3:       return 1'b0;
      default: return l[n];
    endcase
  endfunction

  always_comb f_in = fmodel(mode, lut, int'(n_out));

  typedef struct {
    int          m;
    logic [15:0] l;
    logic [15:0] et;
    logic [4:0]  ec;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] seen_mask(int k);
    int ns;
    ns = (k >= 3) ? (k - 3) / 4 + 1 : 0;
    if (ns >= 16) return 16'hFFFF;
    return 16'((32'd1 << ns) - 1);
  endfunction

  // Full scan with per-cycle checks; optionally pulse start again at cycle rk.
  task automatic run_scan(int m, logic [15:0] l, logic [15:0] et,
                          logic [4:0] ec, int rk);
    logic [15:0] pt;
    mode = m;
    lut  = l;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 66; k++) begin
      if (k > 0) @(negedge clk);
      start = (k == rk);
      if (k < 64) begin
        pt = et & seen_mask(k);
        chk("busy_run", 32'(busy), 32'd1);
        chk("done_run", 32'(done), 32'd0);
        chk("valid_run", 32'(valid), 32'd0);
        chk("n_out_run", 32'(n_out), 32'(k / 4));
        chk("truth_run", 32'(truth), 32'(pt));
        chk("cnt_run", 32'(minterm_cnt), 32'($countones(pt)));
      end else begin
        chk("busy_end", 32'(busy), 32'd0);
        chk("done_end", 32'(done), (k == 64) ? 32'd1 : 32'd0);
        chk("valid_end", 32'(valid), 32'd1);
        chk("n_out_end", 32'(n_out), 32'd0);
        chk("truth_end", 32'(truth), 32'(et));
        chk("cnt_end", 32'(minterm_cnt), 32'(ec));
      end
    end
    start = 1'b0;
  endtask

  task automatic chk_all_zero(string nm);
    chk({nm, "_n_out"}, 32'(n_out), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_valid"}, 32'(valid), 32'd0);
    chk({nm, "_truth"}, 32'(truth), 32'd0);
    chk({nm, "_cnt"}, 32'(minterm_cnt), 32'd0);
  endtask

  initial begin
    int dones;
    logic [15:0] r;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 3;
    lut   = '0;

    vecs[0] = '{0, 16'h0, 16'h0420, 5'd2};
    vecs[1] = '{1, 16'h0, 16'h6996, 5'd8};
    vecs[2] = '{2, 16'h0, 16'hFFFF, 5'd16};
    vecs[3] = '{3, 16'h0, 16'h0000, 5'd0};
    for (int i = 4; i < 7; i++) begin
      r = 16'($urandom);
      vecs[i].m  = 4;
      vecs[i].l  = r;
      vecs[i].et = '0;
      for (int c = 0; c < 16; c++) vecs[i].et[c] = fmodel(4, r, c);
      vecs[i].ec = 5'($countones(vecs[i].et));
    end

    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_scan(vecs[i].m, vecs[i].l, vecs[i].et, vecs[i].ec, -1);

    // Second start at n_out=3 must be ignored.
    run_scan(0, 16'h0, 16'h0420, 5'd2, 12);
    dones = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("restart_no_extra_done", 32'(dones), 32'd0);
    chk("valid_held", 32'(valid), 32'd1);

    // Abort at n_out=7.
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (28) @(negedge clk);
    chk("pre_abort_n_out", 32'(n_out), 32'd7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_all_zero("abort");
    dones = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_scan(1, 16'h0, 16'h6996, 5'd8, -1);

    // Asynchronous reset at n_out=9.
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (36) @(negedge clk);
    chk("pre_reset_n_out", 32'(n_out), 32'd9);
    chk("pre_reset_truth", 32'(truth), 32'h01FF);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // start and abort together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("start_abort_busy2", 32'(busy), 32'd0);
    chk("start_abort_n_out", 32'(n_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
